// File: rtl/sram_rd_stage.sv
// sram_rd_stage: read-side front end for a 64 x 320 1R1W SRAM macro.
// Accepts valid/ready read requests, drives the macro read port, and holds
// returned data in a 2-entry response queue so captured data is immune to
// later writes and to downstream backpressure. A response is bypassed straight
// from the macro when the queue is empty. The write port passes through.
// Optional feature macro: SRAM_RD_STAGE_PERF_EN adds read/stall counters.
module sram_rd_stage #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 320
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [ADDR_W-1:0] io_req_bits_addr,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [DATA_W-1:0] io_resp_bits_data,
  input  logic              io_flush,
  input  logic              io_w_en,
  input  logic [ADDR_W-1:0] io_w_addr,
  input  logic [DATA_W-1:0] io_w_data,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data
`ifdef SRAM_RD_STAGE_PERF_EN
  ,
  output logic [31:0]       io_perf_reads,
  output logic [31:0]       io_perf_stalls
`endif
);

  logic [1:0]        count_q, count_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] entry_q [2];

  logic [1:0] outstanding;
  logic       q_nonempty;
  logic       req_fire;
  logic       resp_fire;
  logic       enq;
  logic       deq;

  // Reads accepted but not yet delivered; only registered state, so no
  // combinational path from io_resp_ready into io_req_ready.
  assign outstanding  = count_q + {1'b0, inflight_q};
  assign io_req_ready = !io_flush && (outstanding < 2'd2);
  assign req_fire     = io_req_valid && io_req_ready;

  assign sram_r_en   = req_fire;
  assign sram_r_addr = req_fire ? io_req_bits_addr : '0;

  assign sram_w_en   = io_w_en;
  assign sram_w_addr = io_w_addr;
  assign sram_w_data = io_w_data;

  // Queue head has priority; otherwise the macro output is bypassed.
  assign q_nonempty        = (count_q != 2'd0);
  assign io_resp_valid     = !io_flush && (q_nonempty || inflight_q);
  assign io_resp_bits_data = q_nonempty ? entry_q[head_q] :
                             (inflight_q ? sram_r_data : '0);
  assign resp_fire         = io_resp_valid && io_resp_ready;

  // Returned data goes into the queue unless it leaves via bypass right now.
  assign deq = resp_fire && q_nonempty;
  assign enq = inflight_q && !io_flush && !(resp_fire && !q_nonempty);

  // Next-state for pointers, occupancy and the in-flight flag.
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = req_fire;
    if (io_flush) begin
      count_d    = 2'd0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
      inflight_d = 1'b0;
    end else begin
      if (enq) tail_d = ~tail_q;
      if (deq) head_d = ~head_q;
      case ({enq, deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
    end
  end

  // Queue storage: one register per entry, written when it is the tail.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    localparam logic IDX = 1'(gi);
    // Capture returned macro data into this entry.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        entry_q[gi] <= '0;
      end else if (enq && (tail_q == IDX)) begin
        entry_q[gi] <= sram_r_data;
      end
    end
  end

`ifdef SRAM_RD_STAGE_PERF_EN
  logic [31:0] perf_reads_q;
  logic [31:0] perf_stalls_q;

  // Free-running counters; flush leaves them alone, wrap at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_reads_q  <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      if (req_fire) perf_reads_q <= perf_reads_q + 32'd1;
      if (io_resp_valid && !io_resp_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign io_perf_reads  = perf_reads_q;
  assign io_perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_sram_rd_stage.sv
// Testbench for sram_rd_stage: contains a behavioural 1R1W write-first SRAM
// model and a reference model that tracks outstanding reads as a FIFO of
// expected data values, fixed at acceptance time.
module tb_sram_rd_stage;
  localparam int AW = 6;
  localparam int DW = 320;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_req_valid;
  logic          io_req_ready;
  logic [AW-1:0] io_req_bits_addr;
  logic          io_resp_valid;
  logic          io_resp_ready;
  logic [DW-1:0] io_resp_bits_data;
  logic          io_flush;
  logic          io_w_en;
  logic [AW-1:0] io_w_addr;
  logic [DW-1:0] io_w_data;
  logic          sram_r_en;
  logic [AW-1:0] sram_r_addr;
  logic [DW-1:0] sram_r_data;
  logic          sram_w_en;
  logic [AW-1:0] sram_w_addr;
  logic [DW-1:0] sram_w_data;
`ifdef SRAM_RD_STAGE_PERF_EN
  logic [31:0]   io_perf_reads;
  logic [31:0]   io_perf_stalls;
`endif

  always #5 clock = ~clock;

  sram_rd_stage #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_req_valid      (io_req_valid),
    .io_req_ready      (io_req_ready),
    .io_req_bits_addr  (io_req_bits_addr),
    .io_resp_valid     (io_resp_valid),
    .io_resp_ready     (io_resp_ready),
    .io_resp_bits_data (io_resp_bits_data),
    .io_flush          (io_flush),
    .io_w_en           (io_w_en),
    .io_w_addr         (io_w_addr),
    .io_w_data         (io_w_data),
    .sram_r_en         (sram_r_en),
    .sram_r_addr       (sram_r_addr),
    .sram_r_data       (sram_r_data),
    .sram_w_en         (sram_w_en),
    .sram_w_addr       (sram_w_addr),
    .sram_w_data       (sram_w_data)
`ifdef SRAM_RD_STAGE_PERF_EN
    ,
    .io_perf_reads     (io_perf_reads),
    .io_perf_stalls    (io_perf_stalls)
`endif
  );

  // SRAM macro model: write-first, read data appears the cycle after R0_en.
  logic [DW-1:0] sram_mem [64];
  always @(posedge clock) begin
    if (sram_w_en) sram_mem[sram_w_addr] <= sram_w_data;
    if (sram_r_en) sram_r_data <= (sram_w_en && sram_w_addr == sram_r_addr) ? sram_w_data
                                                                            : sram_mem[sram_r_addr];
  end

  // Reference state.
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_q [$];
  int unsigned   ref_reads;
  int unsigned   ref_stalls;

  int tests = 0;
  int fails = 0;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_perf();
`ifdef SRAM_RD_STAGE_PERF_EN
    check("perf_reads", DW'(io_perf_reads), DW'(ref_reads));
    check("perf_stalls", DW'(io_perf_stalls), DW'(ref_stalls));
`endif
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic rv, input logic [AW-1:0] ra, input logic rr,
                      input logic fl, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
    logic          exp_ready;
    logic          exp_valid;
    logic          fire;
    logic [DW-1:0] rd_val;
    @(negedge clock);
    io_req_valid     = rv;
    io_req_bits_addr = ra;
    io_resp_ready    = rr;
    io_flush         = fl;
    io_w_en          = we;
    io_w_addr        = wa;
    io_w_data        = wd;
    #1;
    check_perf();
    exp_ready = !fl && (exp_q.size() < 2);
    exp_valid = !fl && (exp_q.size() > 0);
    fire      = rv && exp_ready;
    check("req_ready", DW'(io_req_ready), DW'(exp_ready));
    check("resp_valid", DW'(io_resp_valid), DW'(exp_valid));
    if (exp_valid) check("resp_data", io_resp_bits_data, exp_q[0]);
    check("sram_r_en", DW'(sram_r_en), DW'(fire));
    check("sram_r_addr", DW'(sram_r_addr), fire ? DW'(ra) : '0);
    check("sram_w", {sram_w_en, sram_w_addr, sram_w_data[DW-8:0]}, {we, wa, wd[DW-8:0]});
    if (fire) ref_reads++;
    if (exp_valid && !rr) ref_stalls++;
    rd_val = (we && wa == ra) ? wd : ref_mem[ra];
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rr) void'(exp_q.pop_front());
      if (fire) exp_q.push_back(rd_val);
    end
    if (we) ref_mem[wa] = wd;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, rr, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic rr);
    step(1'b1, a, rr, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, DW'(io_req_ready), DW'(1'b1));
    check({tag, "_valid"}, DW'(io_resp_valid), DW'(1'b0));
    check({tag, "_data"}, io_resp_bits_data, '0);
    check({tag, "_r_en"}, DW'(sram_r_en), DW'(1'b0));
    check_perf();
  endtask

  initial begin
    logic [DW-1:0] pat_a5;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    pat_a5 = {(DW / 8){8'hA5}};
    ref_reads  = 0;
    ref_stalls = 0;
    reset            = 1'b1;
    io_req_valid     = 1'b0;
    io_req_bits_addr = '0;
    io_resp_ready    = 1'b0;
    io_flush         = 1'b0;
    io_w_en          = 1'b0;
    io_w_addr        = '0;
    io_w_data        = '0;

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    check_cleared("reset");
    reset = 1'b0;
    $display("[TB] reset checked");

    // Preload every address through the write port.
    for (int i = 0; i < 64; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, AW'(i), rnd_data());
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, AW'(5), pat_a5);
    $display("[TB] preload done");

    // Single read, bypass latency of one cycle.
    rd(AW'(5), 1'b1);
    idle(1'b1);
    idle(1'b1);
    $display("[TB] single read addr 5");

    // Back-to-back reads at full throughput.
    for (int i = 0; i < 8; i++) rd(AW'(i), 1'b1);
    idle(1'b1);
    idle(1'b1);
    $display("[TB] back-to-back reads 0..7");

    // Backpressure: only two reads accepted; queued data survives a rewrite.
    rd(AW'(1), 1'b0);
    rd(AW'(2), 1'b0);
    rd(AW'(3), 1'b0);
    check("bp_ready_low", DW'(io_req_ready), DW'(1'b0));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(1), rnd_data());
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    $display("[TB] backpressure and rewrite");

    // Same-cycle read and write of one address: write-first.
    step(1'b1, AW'(9), 1'b1, 1'b0, 1'b1, AW'(9), DW'(16'h1234));
    idle(1'b1);
    idle(1'b1);
    $display("[TB] write-first collision");

    // Flush with two queued responses.
    rd(AW'(10), 1'b0);
    rd(AW'(11), 1'b0);
    idle(1'b0);
    step(1'b1, AW'(12), 1'b1, 1'b1, 1'b0, '0, '0);
    idle(1'b1);
    idle(1'b1);
    $display("[TB] flush");

    // Four reads with stalls, then reset mid-burst.
    rd(AW'(20), 1'b1);
    rd(AW'(21), 1'b0);
    rd(AW'(22), 1'b0);
    idle(1'b0);
    idle(1'b1);
    rd(AW'(23), 1'b0);
    @(negedge clock);
    io_req_valid  = 1'b0;
    io_resp_ready = 1'b0;
    io_w_en       = 1'b0;
    io_flush      = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    ref_reads  = 0;
    ref_stalls = 0;
    check_cleared("async_reset");
    @(negedge clock);
    reset = 1'b0;
    $display("[TB] mid-burst asynchronous reset");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      a = AW'($urandom_range(0, 63));
      d = rnd_data();
      step(($urandom % 4) != 0, a, ($urandom % 3) != 0, ($urandom % 25) == 0,
           ($urandom % 2) != 0, (($urandom % 4) == 0) ? a : AW'($urandom_range(0, 63)), d);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_rd_stage.md
# sram_rd_stage

Read-side front end for the 64 x 320 one-read/one-write SRAM array macro used in the frontend data arrays. It accepts valid/ready read requests, drives the macro's read enable and address, and captures returned data into a 2-entry response queue. Captured data is therefore immune to later writes and to downstream backpressure. It also passes the write port through unchanged and supports a flush that discards all outstanding reads.

## Interface
Parameters:
- ADDR_W, 6: SRAM address width (64 entries)
- DATA_W, 320: SRAM data width

Ports:
- clock  in  1  single clock; also drives the macro's R0_clk/W0_clk
- reset  in  1  asynchronous, active-high
- io_req_valid  in  1  read request valid
- io_req_ready  out  1  request accepted when valid & ready
- io_req_bits_addr  in  ADDR_W  read address
- io_resp_valid  out  1  response valid
- io_resp_ready  in  1  downstream accepts response
- io_resp_bits_data  out  DATA_W  response data
- io_flush  in  1  discard in-flight and queued reads
- io_w_en  in  1  write enable (pass-through)
- io_w_addr  in  ADDR_W  write address
- io_w_data  in  DATA_W  write data
- sram_r_en  out  1  to macro R0_en
- sram_r_addr  out  ADDR_W  to macro R0_addr
- sram_r_data  in  DATA_W  from macro R0_data, valid the cycle after sram_r_en
- sram_w_en / sram_w_addr / sram_w_data  out  1/ADDR_W/DATA_W  combinational copies of io_w_*

## Operation
- State:
  - inflight: 1 bit; a read was issued last cycle.
  - Queue: 2 entries, head/tail pointers of 1 bit, count of 0..2.
- io_req_ready = !io_flush & (count + inflight < 2). Uses registered state only; there is no comb path from io_resp_ready.
- Issue (req fire): sram_r_en = 1 and sram_r_addr = io_req_bits_addr. Otherwise sram_r_en = 0 and sram_r_addr = 0.
- Response source:
  - count > 0: queue head.
  - count == 0 & inflight: sram_r_data (bypass).
  - Otherwise io_resp_valid = 0.
- Capture: if inflight and the returned data is not consumed via bypass this cycle, sram_r_data is enqueued at the tail.
- Ordering is strictly FIFO. The enqueue and the dequeue of a different entry may occur in the same cycle.
- Write/read same address, same cycle: write-first. The response carries the new data, which is the macro's natural behaviour.
- A write to an address whose data is already queued does not alter the queued data.
- Flush: in the flush cycle io_resp_valid = 0 and no request is accepted. At the edge, count = 0, pointers = 0 and inflight = 0.

## Timing
- Reset values:
  - All state 0.
  - io_req_ready = 1.
  - io_resp_valid = 0, io_resp_bits_data = 0.
  - sram_r_en = 0.
- Latency: request accepted in cycle T gives io_resp_valid in T+1 (bypass) when the queue is empty.
- Throughput: 1 read/cycle while io_resp_ready stays high.
- Backpressure: with io_resp_ready low, at most 2 reads are accepted. At steady state count = 2 and io_req_ready = 0.
- Full boundary: count + inflight == 2 deasserts io_req_ready in the same cycle the condition holds.
- Dequeue from full while inflight = 0: io_req_ready rises the next cycle.
- Reset asserted mid-operation: state clears immediately (asynchronous); in-flight data is dropped.
- Pointers wrap modulo 2.

## Configuration
- SRAM_RD_STAGE_PERF_EN defined:
  - Adds outputs io_perf_reads [31:0] (count of accepted requests) and io_perf_stalls [31:0] (cycles with io_resp_valid & !io_resp_ready).
  - Both reset to 0 and wrap at 2^32.
  - Flush does not clear them.
- Macro undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, write addr 5 = 0xA5 pattern, read addr 5 with io_resp_ready = 1 -> io_resp_valid in the next cycle with data 0xA5 pattern; io_req_ready stays 1.
- Back-to-back reads of addrs 0..7 with io_resp_ready = 1 -> 8 responses on consecutive cycles, in order, with the correct data.
- io_resp_ready = 0, then attempt reads of addrs 1, 2, 3 -> only 1 and 2 accepted; io_req_ready = 0. Rewrite addr 1 -> released responses are old addr-1 data, then addr-2 data.
- Read addr 9 and write addr 9 = 0x1234 in the same cycle -> response 0x1234.
- Two queued responses, assert io_flush -> io_resp_valid = 0 the next cycle, count 0, io_req_ready = 1.
- PERF_EN: 4 reads with 3 stall cycles -> io_perf_reads = 4, io_perf_stalls = 3; assert reset mid-burst -> both read 0.
